// File: rtl/multicycle_controller_if.sv
// Datapath <-> control-unit bundle for the multicycle RV32I-subset core.
// Carries the decoded instruction fields and ALU zero flag toward the
// controller, and every enable/mux select back toward the datapath.
//   master : datapath side (drives op/funct3/funct7b5/zero, reads controls)
//   slave  : controller side (reads instruction fields, drives controls)
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct3, funct7b5, zero,
    input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
           irwrite, pcwrite, regwrite, memwrite, illegal, state
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
           irwrite, pcwrite, regwrite, memwrite, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I-subset core (lw, sw, R-type,
// I-type ALU, beq, jal). A Moore FSM sequences fetch/decode/execute over
// 3-5 cycles; combinational decoders produce immsrc and alucontrol.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH
//   bus   : slave view of multicycle_controller_if (instruction fields and
//           zero in; all datapath enables/selects, illegal, state out)
module multicycle_controller (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       branch, pcupdate;
  logic [1:0] alusrca, alusrcb, resultsrc, immsrc;
  logic       adrsrc, irwrite, regwrite, memwrite, illegal;
  logic [2:0] alucontrol;

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples the pre-edge value; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore outputs.
  // NOTE: every signal gets a default before the case so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = FETCH;
    aluop     = 2'b00;
    branch    = 1'b0;
    pcupdate  = 1'b0;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        irwrite   = 1'b1;
        pcupdate  = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_ITYPE:     state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD: begin
        state_d = MEMWB;
        adrsrc  = 1'b1;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTER: begin
        state_d = ALUWB;
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      EXECUTEI: begin
        state_d = ALUWB;
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB: regwrite = 1'b1;
      JAL: begin
        state_d  = ALUWB;
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      default: state_d = FETCH;  // unused encodings 11-15 recover
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (bus.op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // ALU decoder. Only R-type (op[5]=1) can select sub on funct3=000;
  // addi carries immediate bits in funct7b5 and must stay add.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.immsrc     = immsrc;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.resultsrc  = resultsrc;
  assign bus.adrsrc     = adrsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.irwrite    = irwrite;
  assign bus.pcwrite    = pcupdate | (branch & bus.zero);
  assign bus.regwrite   = regwrite;
  assign bus.memwrite   = memwrite;
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed reset checks,
// async reset in MEMWRITE, then random instructions against a model.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
  } obs_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ECALL = 7'b1110011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [6:0] op);
    return op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL;
  endfunction

  // States visited by one instruction, as listed in the instruction table.
  function automatic void inst_path(input logic [6:0] op, output int path[$]);
    path = {0, 1};
    if (op == LW)      path = {0, 1, 2, 3, 4};
    else if (op == SW) path = {0, 1, 2, 5};
    else if (op == RT) path = {0, 1, 6, 7};
    else if (op == IT) path = {0, 1, 8, 7};
    else if (op == BQ) path = {0, 1, 10};
    else if (op == JL) path = {0, 1, 9, 7};
  endfunction

  // ALU operation an R/I instruction asks for.
  function automatic logic [2:0] arith_op(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7b5);
    logic [2:0] r;
    r = 3'b000;
    if (f3 == 3'b000 && op == RT && f7b5) r = 3'b001;
    else if (f3 == 3'b010) r = 3'b101;
    else if (f3 == 3'b110) r = 3'b011;
    else if (f3 == 3'b111) r = 3'b010;
    return r;
  endfunction

  function automatic obs_t expect_in(input int st, input logic [6:0] op,
                                     input logic [2:0] f3, input logic f7b5,
                                     input logic z);
    obs_t e;
    e = '0;
    e.state  = 4'(st);
    e.immsrc = (op == SW) ? 2'b01 : (op == BQ) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
    case (st)
      0: begin e.irwrite = 1; e.pcwrite = 1; e.alusrcb = 2; e.resultsrc = 2; end
      1: begin e.alusrca = 1; e.alusrcb = 1; e.illegal = !is_legal(op); end
      2: begin e.alusrca = 2; e.alusrcb = 1; end
      3: e.adrsrc = 1;
      4: begin e.resultsrc = 1; e.regwrite = 1; end
      5: begin e.adrsrc = 1; e.memwrite = 1; end
      6: begin e.alusrca = 2; e.alucontrol = arith_op(op, f3, f7b5); end
      7: e.regwrite = 1;
      8: begin e.alusrca = 2; e.alusrcb = 1; e.alucontrol = arith_op(op, f3, f7b5); end
      9: begin e.alusrca = 1; e.alusrcb = 2; e.pcwrite = 1; end
      10: begin e.alusrca = 2; e.alucontrol = 3'b001; e.pcwrite = z; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    return {bus.state, bus.immsrc, bus.alusrca, bus.alusrcb, bus.resultsrc,
            bus.adrsrc, bus.alucontrol, bus.irwrite, bus.pcwrite,
            bus.regwrite, bus.memwrite, bus.illegal};
  endfunction

  task automatic check(input string tag, input obs_t expected);
    obs_t observed;
    observed = sample();
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h (state obs=%0d exp=%0d)",
             tag, observed, expected, observed.state, expected.state);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7b5, input logic z);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7b5; bus.zero = z;
  endtask

  // Called at a negedge with the DUT in FETCH; walks the whole instruction.
  task automatic run_instr(input string tag, input logic [6:0] op,
                           input logic [2:0] f3, input logic f7b5, input logic z);
    int path[$];
    drive(op, f3, f7b5, z);
    inst_path(op, path);
    foreach (path[i]) begin
      #1;
      check($sformatf("%s st%0d", tag, path[i]), expect_in(path[i], op, f3, f7b5, z));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0] rop;
    int         k;
    drive(7'h00, 3'b000, 1'b0, 1'b0);

    // Reset held with lw in the IR: FETCH outputs throughout.
    drive(LW, 3'b010, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    check("reset_lw", expect_in(0, LW, 3'b010, 1'b0, 1'b0));
    @(negedge clk);
    check("reset_held", expect_in(0, LW, 3'b010, 1'b0, 1'b0));
    reset = 1'b0;

    run_instr("lw", LW, 3'b010, 1'b0, 1'b0);
    run_instr("sw", SW, 3'b010, 1'b0, 1'b0);
    run_instr("sub", RT, 3'b000, 1'b1, 1'b0);
    run_instr("add", RT, 3'b000, 1'b0, 1'b0);
    run_instr("addi", IT, 3'b000, 1'b1, 1'b0);
    run_instr("beq_taken", BQ, 3'b000, 1'b0, 1'b1);
    run_instr("beq_not", BQ, 3'b000, 1'b0, 1'b0);
    run_instr("jal", JL, 3'b000, 1'b0, 1'b0);
    run_instr("illegal", ECALL, 3'b000, 1'b0, 1'b0);

    // Async reset while in MEMWRITE: controls drop before the next edge.
    drive(SW, 3'b010, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) @(negedge clk);
    #1;
    check("pre_async_memwrite", expect_in(5, SW, 3'b010, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1;
    check("async_reset", expect_in(0, SW, 3'b010, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    run_instr("post_reset_sw", SW, 3'b010, 1'b0, 1'b0);

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 6));
      case (k)
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = BQ;
        5: rop = JL;
        default: begin
          rop = 7'($urandom);
          while (is_legal(rop)) rop = 7'($urandom);
        end
      endcase
      run_instr($sformatf("rnd%0d op%b", n, rop), rop, 3'($urandom), 1'($urandom),
                1'($urandom));
    end

    #1;
    check("final_fetch", expect_in(0, bus.op, bus.funct3, bus.funct7b5, bus.zero));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal). A Moore FSM sequences the shared ALU, memory port, instruction register, PC and register file over 3–5 cycles per instruction. Combinational decoders drive the immediate-extender select (immsrc) and the ALU operation. The unit sits beside the datapath: it takes opcode and funct fields from the instruction register and the ALU zero flag, and drives every enable and mux select.

Parameters:
None.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; forces FETCH
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU result == 0
immsrc  output  2  extender select: 00 I, 01 S, 10 B, 11 J
alusrca  output  2  00 PC, 01 oldPC, 10 rs1
alusrcb  output  2  00 rs2, 01 immext, 10 constant 4
resultsrc  output  2  00 ALUOut, 01 memory data, 10 ALU result
adrsrc  output  1  memory address: 0 PC, 1 result
alucontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
irwrite  output  1  load instruction register and oldPC
pcwrite  output  1  load PC
regwrite  output  1  register file write enable
memwrite  output  1  data memory write enable
illegal  output  1  one-cycle pulse: unsupported opcode decoded
state  output  4  current state encoding (debug)

Behaviour:
- Reset: asynchronous. State becomes FETCH (0) immediately and stays FETCH while reset is high. Outputs are pure Moore functions of state, plus the decoders below, so during reset they show FETCH values.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Encodings 11–15 go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH with illegal=1 for that DECODE cycle.
  - MEMADR: op=0000011 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Cycles per instruction: lw 5; sw, R-type, I-type, jal 4; beq 3; illegal 2.
- Per-state outputs. Unlisted signals are 0; selects not listed are 00.
  - FETCH: irwrite=1, pcupdate=1, alusrcb=10, resultsrc=10, aluop=00.
  - DECODE: alusrca=01, alusrcb=01, aluop=00.
  - MEMADR: alusrca=10, alusrcb=01, aluop=00.
  - MEMREAD: adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: regwrite=1.
  - JAL: alusrca=01, alusrcb=10, aluop=00, pcupdate=1.
  - BEQ: alusrca=10, aluop=01, branch=1.
- pcwrite = pcupdate | (branch & zero). zero is sampled combinationally in BEQ.
- immsrc is decoded from op in every state: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all other op values -> 00.
- alucontrol decode:
  - aluop 00 -> 000; aluop 01 -> 001.
  - aluop 10, funct3 000: sub (001) if op[5] & funct7b5, else add (000).
  - aluop 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- No X values on any output in any state, including unused encodings.
- Reset asserted mid-instruction (e.g. in MEMWRITE) drops memwrite and regwrite in the same cycle, with no clock edge needed.

Test Plan:
- Reset: assert reset with op=0000011 -> state=0, irwrite=1, pcwrite=1, regwrite=0, memwrite=0. After release, state sequence 0,1,2,3,4,0. regwrite=1 only in state 4, with resultsrc=01.
- sw: op=0100011 -> states 0,1,2,5,0. immsrc=01 throughout; memwrite=1 and adrsrc=1 only in state 5.
- R-type sub: op=0110011, funct3=000, funct7b5=1 -> alucontrol=001 in EXECUTER. Same with funct7b5=0 -> 000. I-type op=0010011, funct7b5=1 -> 000 (addi is never sub).
- beq: op=1100011 in BEQ with zero=1 -> pcwrite=1, alucontrol=001. With zero=0 -> pcwrite=0. Both return to FETCH after 3 cycles.
- jal and illegal: op=1101111 -> states 0,1,9,7,0 with immsrc=11 and pcwrite=1 in JAL. Then op=1110011 -> illegal=1 for one cycle in DECODE, next state 0.
- Async reset: assert reset mid-cycle while in MEMWRITE -> memwrite falls and state=0 before the next clk edge.
